// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions used by the fetch stage and the control unit.
package mips_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic [31:0]        addr;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous in-order FIFO; flush wins over push and pop.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && !flush && (count_q != '0);
        // A push into a full queue is only legal alongside a pop.
        do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// MIPS-32 instruction fetch: PC, imem request/response tracking, redirect
// with stale-response dropping, and a decoded view of the queue head.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imemReq,
    output logic [31:0]        imemAddr,
    input  logic               imemReady,
    input  logic               imemValid,
    input  logic [INSTR_W-1:0] imemRdata,
    input  logic               branchTaken,
    input  logic [31:0]        branchTarget,
    output logic               instrValid,
    input  logic               instrReady,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [5:0]         funct5,
    output logic [31:0]        pcPlus4
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] q_count;
    logic             fire, resp_v, drop, push, pop;
    logic [31:0]      target_aligned;
    logic [31:0]      occupancy;
    fetch_entry_t     push_entry, head_entry;
    logic [FETCH_ENTRY_W-1:0] head_bits;

    assign target_aligned = branchTarget & 32'hFFFF_FFFC;
    // Reserve a queue slot for every outstanding request so the queue cannot overflow.
    assign occupancy      = 32'(inflight_q) + 32'(q_count);

    assign imemReq  = !reset && !branchTaken && (occupancy < DEPTH);
    assign imemAddr = pc_q;
    assign fire     = imemReq && imemReady;

    // A response with nothing in flight is stray and ignored.
    assign resp_v = imemValid && (inflight_q != '0);
    assign drop   = resp_v && (drop_cnt_q != '0);
    assign push   = resp_v && !drop;
    assign pop    = instrValid && instrReady;

    assign push_entry = '{data: imemRdata, addr: resp_pc_q};

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(resp_v);
        drop_cnt_d = drop_cnt_q - CNT_W'(drop);
        if (branchTaken) begin
            pc_d       = target_aligned;
            resp_pc_d  = target_aligned;
            // inflight already includes responses earmarked for dropping, so every
            // request still outstanding after this cycle's response becomes stale.
            drop_cnt_d = inflight_q - CNT_W'(resp_v);
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wdata     (push_entry),
        .pop       (pop),
        .flush     (branchTaken),
        .count     (q_count),
        .head_data (head_bits)
    );

    assign head_entry = fetch_entry_t'(head_bits);

    always_comb begin
        instrValid = (q_count != '0);
        instr      = instrValid ? head_entry.data : NOP_INSTR;
        opcode     = instr[OPCODE_MSB:OPCODE_LSB];
        funct5     = instr[FUNCT_MSB:FUNCT_LSB];
        pcPlus4    = (instrValid ? head_entry.addr : resp_pc_q) + 32'd4;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        stray_resp_a: assert (reset || !(imemValid && inflight_q == '0))
            else $error("instr_fetch: imemValid with no request in flight");
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table, redirect/stall/reset sequences, random soak.
module tb_instr_fetch;
    import mips_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, imemReq, imemReady, imemValid, branchTaken;
    logic        instrValid, instrReady;
    logic [31:0] imemAddr, imemRdata, branchTarget, instr, pcPlus4;
    logic [5:0]  opcode, funct5;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemReady    (imemReady),
        .imemValid    (imemValid),
        .imemRdata    (imemRdata),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .instr        (instr),
        .opcode       (opcode),
        .funct5       (funct5),
        .pcPlus4      (pcPlus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc4;
    } vec_t;

    req_t        pend[$];
    vec_t        vecs[9];
    int          cyc, n_cmp, n_bad, pops, fires, lat_lo, lat_hi;
    bit          rand_valid;
    logic [31:0] exp_pc, last_fire;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:2], 20'hC0DE5, a[7:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // Samples the cycle's handshakes, checks pops against the scoreboard, then advances
    // the memory model past the rising edge.
    task automatic to_edge();
        bit          f, rt, p, br, rs;
        logic [31:0] fa, tgt, w;
        f   = imemReq && imemReady;
        fa  = imemAddr;
        rt  = imemValid;
        p   = instrValid && instrReady && !branchTaken && !reset;
        br  = branchTaken;
        rs  = reset;
        tgt = branchTarget;
        if (imemReq) check("addr_align", {30'b0, imemAddr[1:0]}, 32'd0);
        check("outstanding_le_depth", 32'(pend.size() <= int'(DEPTH)), 32'd1);
        if (p) begin
            w = word_of(exp_pc);
            check("pop_pcplus4", pcPlus4, exp_pc + 32'd4);
            check("pop_instr", instr, w);
            check("pop_opcode", 32'(opcode), 32'(w[31:26]));
            check("pop_funct5", 32'(funct5), 32'(w[5:0]));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        @(posedge clk);
        cyc++;
        if (rs) begin
            pend.delete();
            exp_pc = RESET_PC;
        end else begin
            if (rt && pend.size() > 0) void'(pend.pop_front());
            if (f) begin
                pend.push_back('{fa, cyc - 1 + int'($urandom_range(lat_hi, lat_lo))});
                fires++;
                last_fire = fa;
            end
            if (br) exp_pc = {tgt[31:2], 2'b00};
        end
        #1;
        imemValid = 1'b0;
        imemRdata = '0;
        if (pend.size() > 0 && pend[0].due <= cyc && (!rand_valid || $urandom_range(0, 3) != 0)) begin
            imemValid = 1'b1;
            imemRdata = word_of(pend[0].addr);
        end
    endtask

    task automatic tick();
        to_sample();
        to_edge();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        branchTaken = 1'b0;
        instrReady  = 1'b0;
        imemReady   = 1'b1;
        rand_valid  = 1'b0;
        lat_lo      = 1;
        lat_hi      = 1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int i, base_pops, base_fires;
        n_cmp = 0; n_bad = 0; pops = 0; fires = 0; cyc = 0;
        exp_pc = RESET_PC; last_fire = '0;
        reset = 1'b1; imemReady = 1'b1; imemValid = 1'b0; imemRdata = '0;
        branchTaken = 1'b0; branchTarget = '0; instrReady = 1'b0;
        rand_valid = 1'b0; lat_lo = 1; lat_hi = 1;

        // {instrReady, imemReq, imemAddr, instrValid, pcPlus4} per cycle out of reset, 1-cycle memory.
        vecs[0] = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        vecs[3] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
        vecs[4] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        vecs[5] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd16};
        vecs[6] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd20};
        vecs[7] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd20};
        vecs[8] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd24};

        // Reset state, sampled while reset is held.
        tick();
        to_sample();
        check("rst_imemReq", 32'(imemReq), 32'd0);
        check("rst_imemAddr", imemAddr, RESET_PC);
        check("rst_instrValid", 32'(instrValid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_funct5", 32'(funct5), 32'd0);
        check("rst_pcPlus4", pcPlus4, RESET_PC + 32'd4);
        to_edge();
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            instrReady = vecs[v].rdy;
            to_sample();
            check($sformatf("vec%0d_req", v), 32'(imemReq), 32'(vecs[v].req));
            check($sformatf("vec%0d_addr", v), imemAddr, vecs[v].addr);
            check($sformatf("vec%0d_valid", v), 32'(instrValid), 32'(vecs[v].vld));
            check($sformatf("vec%0d_instr", v), instr,
                  vecs[v].vld ? word_of(vecs[v].pc4 - 32'd4) : 32'd0);
            if (vecs[v].vld) check($sformatf("vec%0d_pc4", v), pcPlus4, vecs[v].pc4);
            to_edge();
        end

        // Decode stalled: exactly DEPTH requests, then resume at 16 when drained.
        do_reset();
        fires = 0;
        for (int k = 0; k < 8; k++) tick();
        check("stall_fires", 32'(fires), 32'd4);
        to_sample();
        check("stall_req_low", 32'(imemReq), 32'd0);
        check("stall_head", instr, word_of(32'd0));
        to_edge();
        instrReady = 1'b1;
        base_pops  = pops;
        for (i = 0; i < 20 && fires < 5; i++) tick();
        check("stall_resume_addr", last_fire, 32'd16);
        for (int k = 0; k < 4; k++) tick();
        check("stall_drained", 32'(pops - base_pops >= 4), 32'd1);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat_lo = 3; lat_hi = 3; instrReady = 1'b1;
        tick();
        tick();
        branchTaken = 1'b1; branchTarget = 32'h0000_0103;
        to_sample();
        check("redir_no_req", 32'(imemReq), 32'd0);
        to_edge();
        branchTaken = 1'b0;
        to_sample();
        check("redir_req", 32'(imemReq), 32'd1);
        check("redir_addr", imemAddr, 32'h0000_0100);
        check("redir_empty", 32'(instrValid), 32'd0);
        to_edge();
        for (i = 0; i < 10; i++) begin
            to_sample();
            if (instrValid) break;
            to_edge();
        end
        if (i == 10) to_sample();
        check("redir_delay", 32'(i), 32'd3);
        check("redir_first_pc4", pcPlus4, 32'h0000_0104);
        check("redir_first_instr", instr, word_of(32'h0000_0100));
        to_edge();

        // Redirect coinciding with a response, a pop and imemReady.
        do_reset();
        instrReady = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        branchTaken = 1'b1; branchTarget = 32'h0000_0200;
        to_sample();
        check("same_pre", {29'b0, imemValid, instrValid, imemReady}, 32'd7);
        check("same_no_req", 32'(imemReq), 32'd0);
        base_fires = fires;
        to_edge();
        branchTaken = 1'b0;
        check("same_no_fire", 32'(fires - base_fires), 32'd0);
        to_sample();
        check("same_flushed", 32'(instrValid), 32'd0);
        check("same_addr", imemAddr, 32'h0000_0200);
        to_edge();
        for (i = 0; i < 8; i++) begin
            to_sample();
            if (instrValid) break;
            to_edge();
        end
        if (i == 8) to_sample();
        check("same_delay", 32'(i), 32'd1);
        check("same_first_pc4", pcPlus4, 32'h0000_0204);
        to_edge();

        // Random memory latency, stalls and redirects (including one near the wrap point).
        do_reset();
        rand_valid = 1'b1; lat_lo = 1; lat_hi = 4;
        base_pops = pops;
        for (int k = 0; k < 3000; k++) begin
            imemReady   = ($urandom_range(0, 3) != 0);
            instrReady  = ($urandom_range(0, 3) != 0);
            branchTaken = (k == 1500) || ($urandom_range(0, 49) == 0);
            branchTarget = (k == 1500) ? 32'hFFFF_FFF6 : $urandom;
            tick();
        end
        branchTaken = 1'b0;
        check("rand_progress", 32'(pops - base_pops > 300), 32'd1);

        // Reset mid-stream with a full queue.
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        to_sample();
        check("mid_full", 32'(instrValid), 32'd1);
        to_edge();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        to_sample();
        check("mid_valid", 32'(instrValid), 32'd0);
        check("mid_addr", imemAddr, RESET_PC);
        check("mid_req", 32'(imemReq), 32'd1);
        check("mid_instr", instr, 32'd0);
        to_edge();
        instrReady = 1'b1;
        base_pops  = pops;
        for (int k = 0; k < 10; k++) tick();
        check("mid_restart", 32'(pops - base_pops >= 6), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
